// File: rtl/sdspi_host_pkg.sv
// Shared definitions for the SD-card SPI host: FSM states, response error codes,
// SD command indices and the CRC7 (command) / CRC16-CCITT (data) helpers.
package sdspi_host_pkg;

  typedef enum logic [3:0] {
    StInit, StIdle, StCmd, StWaitR1, StExt, StWaitToken, StData, StCrc, StGap
  } state_e;

  localparam logic [1:0] ErrOk           = 2'd0;
  localparam logic [1:0] ErrR1Timeout    = 2'd1;
  localparam logic [1:0] ErrTokenTimeout = 2'd2;
  localparam logic [1:0] ErrDataCrc      = 2'd3;

  localparam logic [5:0] CmdGoIdle      = 6'd0;
  localparam logic [5:0] CmdSendIfCond  = 6'd8;
  localparam logic [5:0] CmdReadMulti   = 6'd18;
  localparam logic [5:0] AcmdSendOpCond = 6'd41;
  localparam logic [5:0] CmdAppCmd      = 6'd55;
  localparam logic [5:0] CmdReadOcr     = 6'd58;

  localparam logic [7:0]  TokenStart = 8'hFE;
  localparam int unsigned InitBytes  = 10;

  // CRC7, polynomial x^7 + x^3 + 1, one byte MSB first
  function automatic logic [6:0] crc7_byte(input logic [6:0] crc, input logic [7:0] b);
    logic [6:0] c;
    logic       fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[6] ^ b[i];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  // CRC7 over the first five bytes of a command frame, init 0
  function automatic logic [6:0] crc7_frame(input logic [39:0] f);
    logic [6:0] c;
    c = 7'h00;
    for (int i = 4; i >= 0; i--) c = crc7_byte(c, f[8*i +: 8]);
    return c;
  endfunction

  // CRC16-CCITT, polynomial 0x1021, one byte MSB first
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[15] ^ b[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

endpackage

// File: rtl/sdspi_byte_xfer.sv
// One SPI mode-0 byte transfer: SCK divider plus 8-bit full-duplex shifter.
// Ports: i_clk/i_rst (sync, active-high); i_start pulse with i_tx loads a byte;
// o_done pulses for one cycle with o_rx holding the received byte;
// o_sck/o_mosi drive the card, i_miso is sampled on each SCK rising edge.
module sdspi_byte_xfer #(
  parameter int unsigned sck_half = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [7:0] i_tx,
  output logic       o_done,
  output logic [7:0] o_rx,
  output logic       o_sck,
  output logic       o_mosi,
  input  logic       i_miso
);
  localparam int unsigned DivW = $clog2(sck_half);

  logic            r_busy;
  logic [DivW-1:0] r_div;
  logic [3:0]      r_half;
  logic            r_sck;
  logic [7:0]      r_tx;
  logic [7:0]      r_rx;
  logic            r_done;

  // Even half-periods are SCK low, odd ones high; 16 halves make one byte.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_busy <= 1'b0;
      r_div  <= '0;
      r_half <= '0;
      r_sck  <= 1'b0;
      r_tx   <= 8'hFF;
      r_rx   <= 8'hFF;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (!r_busy) begin
        if (i_start) begin
          r_busy <= 1'b1;
          r_tx   <= i_tx;
          r_div  <= '0;
          r_half <= '0;
        end
      end else if (r_div == DivW'(sck_half - 1)) begin
        r_div  <= '0;
        r_half <= r_half + 4'd1;
        if (!r_half[0]) begin
          r_sck <= 1'b1;
          r_rx  <= {r_rx[6:0], i_miso};
        end else begin
          r_sck <= 1'b0;
          r_tx  <= {r_tx[6:0], 1'b1};
          if (r_half == 4'd15) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
          end
        end
      end else begin
        r_div <= r_div + DivW'(1);
      end
    end
  end

  assign o_done = r_done;
  assign o_rx   = r_rx;
  assign o_sck  = r_sck;
  assign o_mosi = r_busy ? r_tx[7] : 1'b1;

endmodule

// File: rtl/sdspi_host.sv
// SD-card SPI-mode host: power-up clocking, command frame with CRC7, R1 wait,
// optional 4-byte R3/R7 tail, optional single-block read with CRC16 check.
// Ports: i_clk/i_rst (sync, active-high); command request i_cmd_* with
// i_cmd_valid/o_cmd_ready; result o_resp_* (o_resp_valid one-cycle pulse);
// block bytes o_data/o_data_valid/o_data_last; card bus o_sck/o_csn/o_mosi/i_miso.
module sdspi_host
  import sdspi_host_pkg::*;
#(
  parameter int unsigned sck_half      = 4,
  parameter int unsigned block_size    = 512,
  parameter int unsigned resp_timeout  = 64,
  parameter int unsigned token_timeout = 4096
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [5:0]  i_cmd_idx,
  input  logic [31:0] i_cmd_arg,
  input  logic        i_cmd_ext,
  input  logic        i_cmd_data,
  output logic        o_resp_valid,
  output logic [7:0]  o_resp_r1,
  output logic [31:0] o_resp_ext,
  output logic [1:0]  o_resp_err,
  output logic        o_data_valid,
  output logic [7:0]  o_data,
  output logic        o_data_last,
  output logic        o_sck,
  output logic        o_csn,
  output logic        o_mosi,
  input  logic        i_miso
);
  localparam int unsigned CntA   = (block_size > token_timeout) ? block_size : token_timeout;
  localparam int unsigned CntB   = (CntA > resp_timeout) ? CntA : resp_timeout;
  localparam int unsigned CntMax = (CntB > InitBytes) ? CntB : InitBytes;
  localparam int unsigned CntW   = $clog2(CntMax);

  state_e r_state, w_state;
  logic [CntW-1:0] r_cnt, w_cnt, w_cnt_inc;
  logic [5:0]  r_idx, w_idx;
  logic [31:0] r_arg, w_arg;
  logic        r_ext_req, w_ext_req, r_data_req, w_data_req;
  logic        r_csn, w_csn, r_inflight, w_inflight;
  logic [7:0]  r_r1, w_r1, r_data, w_data, r_crc_hi, w_crc_hi;
  logic [31:0] r_ext, w_ext;
  logic [1:0]  r_err, w_err;
  logic [15:0] r_crc, w_crc;
  logic        r_data_valid, w_data_valid, r_data_last, w_data_last;
  logic        r_resp_valid, w_resp_valid;
  logic        w_start, w_done;
  logic [7:0]  w_tx, w_rx;
  logic [6:0]  w_crc7;

  sdspi_byte_xfer #(.sck_half(sck_half)) u_xfer (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_start(w_start),
    .i_tx   (w_tx),
    .o_done (w_done),
    .o_rx   (w_rx),
    .o_sck  (o_sck),
    .o_mosi (o_mosi),
    .i_miso (i_miso)
  );

  assign w_crc7    = crc7_frame({2'b01, r_idx, r_arg});
  assign w_cnt_inc = r_cnt + CntW'(1);

  always_comb begin
    w_state = r_state;   w_cnt = r_cnt;         w_idx = r_idx;        w_arg = r_arg;
    w_ext_req = r_ext_req; w_data_req = r_data_req; w_csn = r_csn;   w_r1 = r_r1;
    w_ext = r_ext;       w_err = r_err;         w_crc = r_crc;        w_crc_hi = r_crc_hi;
    w_data = r_data;     w_data_valid = 1'b0;   w_data_last = 1'b0;   w_resp_valid = 1'b0;
    w_tx = 8'hFF;
    w_start = 1'b0;
    w_inflight = r_inflight;

    // Every non-idle state shifts bytes back to back; one byte in flight at a time.
    if (r_state != StIdle && !r_inflight) begin
      w_start    = 1'b1;
      w_inflight = 1'b1;
    end
    if (w_done) w_inflight = 1'b0;

    if (r_state == StCmd) begin
      case (r_cnt[2:0])
        3'd0:    w_tx = {2'b01, r_idx};
        3'd1:    w_tx = r_arg[31:24];
        3'd2:    w_tx = r_arg[23:16];
        3'd3:    w_tx = r_arg[15:8];
        3'd4:    w_tx = r_arg[7:0];
        default: w_tx = {w_crc7, 1'b1};
      endcase
    end

    case (r_state)
      StInit: if (w_done) begin
        if (r_cnt == CntW'(InitBytes - 1)) begin
          w_state = StIdle;
          w_cnt   = '0;
        end else w_cnt = w_cnt_inc;
      end
      StIdle: if (i_cmd_valid) begin
        w_idx = i_cmd_idx;   w_arg = i_cmd_arg;
        w_ext_req = i_cmd_ext; w_data_req = i_cmd_data;
        w_csn = 1'b0;  w_cnt = '0;  w_r1 = 8'hFF;  w_ext = '0;  w_err = ErrOk;
        w_state = StCmd;
      end
      StCmd: if (w_done) begin
        if (r_cnt == CntW'(5)) begin
          w_state = StWaitR1;
          w_cnt   = '0;
        end else w_cnt = w_cnt_inc;
      end
      StWaitR1: if (w_done) begin
        if (!w_rx[7]) begin
          w_r1  = w_rx;
          w_cnt = '0;
          if (r_ext_req)                        w_state = StExt;
          else if (r_data_req && w_rx == 8'h00) w_state = StWaitToken;
          else begin
            w_state = StGap;
            w_csn   = 1'b1;
          end
        end else if (r_cnt == CntW'(resp_timeout - 1)) begin
          w_err   = ErrR1Timeout;
          w_state = StGap;
          w_csn   = 1'b1;
        end else w_cnt = w_cnt_inc;
      end
      StExt: if (w_done) begin
        w_ext = {r_ext[23:0], w_rx};
        if (r_cnt == CntW'(3)) begin
          w_cnt = '0;
          if (r_data_req && r_r1 == 8'h00) w_state = StWaitToken;
          else begin
            w_state = StGap;
            w_csn   = 1'b1;
          end
        end else w_cnt = w_cnt_inc;
      end
      StWaitToken: if (w_done) begin
        if (w_rx == TokenStart) begin
          w_state = StData;
          w_cnt   = '0;
          w_crc   = '0;
        end else if (r_cnt == CntW'(token_timeout - 1)) begin
          w_err   = ErrTokenTimeout;
          w_state = StGap;
          w_csn   = 1'b1;
        end else w_cnt = w_cnt_inc;
      end
      StData: if (w_done) begin
        w_data       = w_rx;
        w_data_valid = 1'b1;
        w_crc        = crc16_byte(r_crc, w_rx);
        if (r_cnt == CntW'(block_size - 1)) begin
          w_data_last = 1'b1;
          w_cnt       = '0;
          w_state     = StCrc;
        end else w_cnt = w_cnt_inc;
      end
      StCrc: if (w_done) begin
        w_crc_hi = w_rx;
        if (r_cnt == CntW'(1)) begin
          if ({r_crc_hi, w_rx} != r_crc) w_err = ErrDataCrc;
          w_state = StGap;
          w_csn   = 1'b1;
        end else w_cnt = w_cnt_inc;
      end
      StGap: if (w_done) begin
        w_resp_valid = 1'b1;
        w_state      = StIdle;
      end
      default: w_state = StInit;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StInit;  r_cnt <= '0;       r_idx <= '0;       r_arg <= '0;
      r_ext_req <= 1'b0;  r_data_req <= 1'b0; r_csn <= 1'b1;    r_inflight <= 1'b0;
      r_r1 <= 8'hFF;      r_ext <= '0;       r_err <= ErrOk;    r_crc <= '0;
      r_crc_hi <= '0;     r_data <= '0;      r_data_valid <= 1'b0;
      r_data_last <= 1'b0; r_resp_valid <= 1'b0;
    end else begin
      r_state <= w_state;  r_cnt <= w_cnt;    r_idx <= w_idx;    r_arg <= w_arg;
      r_ext_req <= w_ext_req; r_data_req <= w_data_req; r_csn <= w_csn;
      r_inflight <= w_inflight; r_r1 <= w_r1; r_ext <= w_ext;   r_err <= w_err;
      r_crc <= w_crc;      r_crc_hi <= w_crc_hi; r_data <= w_data;
      r_data_valid <= w_data_valid; r_data_last <= w_data_last;
      r_resp_valid <= w_resp_valid;
    end
  end

  assign o_cmd_ready  = (r_state == StIdle) && !i_rst;
  assign o_csn        = r_csn;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_r1    = r_r1;
  assign o_resp_ext   = r_ext;
  assign o_resp_err   = r_err;
  assign o_data_valid = r_data_valid;
  assign o_data       = r_data;
  assign o_data_last  = r_data_last;

endmodule

// File: tb/tb_sdspi_host.sv
// Directed bench for sdspi_host with a behavioural SPI-mode SD card model.
module tb_sdspi_host;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [5:0]  cmd_idx = '0;
  logic [31:0] cmd_arg = '0;
  logic        cmd_ext = 1'b0;
  logic        cmd_data = 1'b0;
  logic        resp_valid, data_valid, data_last;
  logic [7:0]  resp_r1, data;
  logic [31:0] resp_ext;
  logic [1:0]  resp_err;
  logic        sck, csn, mosi, miso;

  always #5 clk = ~clk;

  sdspi_host #(.sck_half(2)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_idx(cmd_idx), .i_cmd_arg(cmd_arg), .i_cmd_ext(cmd_ext), .i_cmd_data(cmd_data),
    .o_resp_valid(resp_valid), .o_resp_r1(resp_r1), .o_resp_ext(resp_ext),
    .o_resp_err(resp_err),
    .o_data_valid(data_valid), .o_data(data), .o_data_last(data_last),
    .o_sck(sck), .o_csn(csn), .o_mosi(mosi), .i_miso(miso)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- SD card model ----------------
  logic        miso_high = 1'b0;
  logic [7:0]  m_tx = 8'hFF;
  logic [7:0]  m_rx = 8'hFF;
  int          m_bits = 0;
  logic [7:0]  m_cmd [6];
  int          m_cmd_n = 0;
  logic [47:0] m_frame = '0;
  logic [7:0]  m_q [$];
  logic        m_idle = 1'b0;
  logic        m_app = 1'b0;
  logic        p_sck = 1'b0;
  logic        p_csn = 1'b1;

  assign miso = miso_high | csn | m_tx[7];

  task automatic card_cmd();
    logic [5:0] idx;
    idx = m_cmd[0][5:0];
    m_q.push_back(8'hFF);
    case (idx)
      6'd0: begin
        m_idle = 1'b1;
        m_q.push_back(8'h01);
      end
      6'd8: begin
        m_q.push_back({7'd0, m_idle});
        for (int i = 1; i <= 4; i++) m_q.push_back(m_cmd[i]);
      end
      6'd55: m_q.push_back({7'd0, m_idle});
      6'd41: begin
        if (m_app) begin
          m_idle = 1'b0;
          m_q.push_back(8'h00);
        end else m_q.push_back({5'd0, 1'b1, 1'b0, m_idle});
      end
      6'd58: begin
        m_q.push_back({7'd0, m_idle});
        m_q.push_back(8'hC0); m_q.push_back(8'hFF);
        m_q.push_back(8'h80); m_q.push_back(8'h00);
      end
      6'd18: begin
        m_q.push_back(8'h00);
        m_q.push_back(8'hFF); m_q.push_back(8'hFF); m_q.push_back(8'hFE);
        for (int i = 0; i < 512; i++) m_q.push_back(8'(i));
        m_q.push_back(8'h11); m_q.push_back(8'h22);
      end
      default: m_q.push_back({5'd0, 1'b1, 1'b0, m_idle});
    endcase
    m_app = (idx == 6'd55);
  endtask

  task automatic card_byte(input logic [7:0] b);
    if (m_cmd_n == 0 && b[7:6] != 2'b01) return;
    m_cmd[m_cmd_n] = b;
    m_cmd_n++;
    if (m_cmd_n == 6) begin
      m_cmd_n = 0;
      m_frame = {m_cmd[0], m_cmd[1], m_cmd[2], m_cmd[3], m_cmd[4], m_cmd[5]};
      card_cmd();
    end
  endtask

  always @(sck or csn) begin
    if (csn !== p_csn) begin
      m_q.delete();
      m_bits  = 0;
      m_cmd_n = 0;
      m_tx    = 8'hFF;
    end else if (!csn && sck && !p_sck) begin
      m_rx = {m_rx[6:0], mosi};
      m_bits++;
    end else if (!csn && !sck && p_sck) begin
      if (m_bits == 8) begin
        m_bits = 0;
        card_byte(m_rx);
        m_tx = (m_q.size() > 0) ? m_q.pop_front() : 8'hFF;
      end else m_tx = {m_tx[6:0], 1'b1};
    end
    p_sck = sck;
    p_csn = csn;
  end

  // ---------------- monitors ----------------
  int sck_total = 0;
  int rv_total = 0;
  int d_cnt = 0, d_bad = 0, d_last_idx = -1, d_last_cnt = 0;

  always @(posedge sck) sck_total++;

  always @(negedge clk) begin
    if (resp_valid) rv_total++;
    if (data_valid) begin
      if (data !== 8'(d_cnt)) d_bad++;
      if (data_last) begin
        d_last_idx = d_cnt;
        d_last_cnt++;
      end
      d_cnt++;
    end
  end

  // ---------------- sequences ----------------
  logic [7:0]  g_r1;
  logic [31:0] g_ext;
  logic [1:0]  g_err;
  int          g_sck;

  task automatic init_check(input string tag);
    int s, n;
    logic low;
    s = sck_total; low = 1'b0; n = 0;
    while (!cmd_ready && n < 5000) begin
      @(negedge clk);
      if (!csn) low = 1'b1;
      n++;
    end
    check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, "_sck_edges"}, 32'(sck_total - s), 32'd80);
    check({tag, "_csn_high"}, 32'(low), 32'd0);
  endtask

  task automatic accept(input logic [5:0] idx, input logic [31:0] arg,
                        input logic ext, input logic dat);
    int n;
    n = 0;
    while (!cmd_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    cmd_idx = idx; cmd_arg = arg; cmd_ext = ext; cmd_data = dat;
    cmd_valid = 1'b1;
    @(posedge clk);
    g_sck = sck_total;
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("csn_low_after_accept", 32'(csn), 32'd0);
  endtask

  task automatic do_cmd(input logic [5:0] idx, input logic [31:0] arg,
                        input logic ext, input logic dat);
    int n;
    accept(idx, arg, ext, dat);
    n = 0;
    while (!resp_valid && n < 60000) begin
      @(negedge clk);
      n++;
    end
    check("resp_valid_seen", 32'(resp_valid), 32'd1);
    g_r1  = resp_r1;
    g_ext = resp_ext;
    g_err = resp_err;
    g_sck = sck_total - g_sck;
  endtask

  initial begin
    int rv_snap;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_csn", 32'(csn), 32'd1);
    check("rst_sck_mosi", {30'd0, sck, mosi}, 32'b01);
    check("rst_ready_valids", {28'd0, cmd_ready, resp_valid, data_valid, data_last}, 32'd0);
    check("rst_r1", 32'(resp_r1), 32'hFF);
    check("rst_ext", resp_ext, 32'd0);
    check("rst_err_data", {22'd0, resp_err, data}, 32'd0);
    rst = 1'b0;
    init_check("init");

    // CMD8 while the card is in its power-up (non-idle) state
    do_cmd(6'd8, 32'h0000_01AA, 1'b1, 1'b0);
    check("cmd8_r1", 32'(g_r1), 32'h00);
    check("cmd8_ext", g_ext, 32'h0000_01AA);
    check("cmd8_crc_byte", 32'(m_frame[7:0]), 32'h87);

    do_cmd(6'd0, 32'd0, 1'b0, 1'b0);
    check("cmd0_frame_hi", m_frame[47:16], 32'h4000_0000);
    check("cmd0_frame_lo", 32'(m_frame[15:0]), 32'h0095);
    check("cmd0_r1", 32'(g_r1), 32'h01);
    check("cmd0_err", 32'(g_err), 32'd0);

    do_cmd(6'd5, 32'd0, 1'b0, 1'b0);
    check("cmd5_r1", 32'(g_r1), 32'h05);

    do_cmd(6'd55, 32'd0, 1'b0, 1'b0);
    check("cmd55_r1", 32'(g_r1), 32'h01);
    do_cmd(6'd41, 32'h4000_0000, 1'b0, 1'b0);
    check("acmd41_r1", 32'(g_r1), 32'h00);
    do_cmd(6'd58, 32'd0, 1'b1, 1'b0);
    check("cmd58_r1", 32'(g_r1), 32'h00);
    check("cmd58_ext", g_ext, 32'hC0FF_8000);
    check("cmd58_err", 32'(g_err), 32'd0);

    d_cnt = 0; d_bad = 0; d_last_idx = -1; d_last_cnt = 0;
    do_cmd(6'd18, 32'd0, 1'b0, 1'b1);
    check("cmd18_r1", 32'(g_r1), 32'h00);
    check("cmd18_err", 32'(g_err), 32'd3);
    check("cmd18_ext_zero", g_ext, 32'd0);
    check("cmd18_bytes", 32'(d_cnt), 32'd512);
    check("cmd18_data_bad", 32'(d_bad), 32'd0);
    check("cmd18_last_idx", 32'(d_last_idx), 32'd511);
    check("cmd18_last_cnt", 32'(d_last_cnt), 32'd1);

    // No card answer: 6 command + 64 response + 1 gap bytes
    miso_high = 1'b1;
    do_cmd(6'd0, 32'd0, 1'b0, 1'b0);
    check("timeout_r1", 32'(g_r1), 32'hFF);
    check("timeout_err", 32'(g_err), 32'd1);
    check("timeout_sck_edges", 32'(g_sck), 32'd568);
    miso_high = 1'b0;

    // Reset in the middle of a command frame
    accept(6'd0, 32'd0, 1'b0, 1'b0);
    rv_snap = rv_total;
    repeat (40) @(negedge clk);
    check("midframe_csn_low", 32'(csn), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("abort_csn", 32'(csn), 32'd1);
    check("abort_sck_mosi_ready", {29'd0, sck, mosi, cmd_ready}, 32'b010);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    init_check("reinit");
    check("abort_no_resp", 32'(rv_total - rv_snap), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
